// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle control FSM with memory wait states, JAL, trap and retire counter
module multicycle_controller #(
  parameter int CNT_W    = 32,
  parameter bit HAS_JAL  = 1'b1,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adrsrc,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             regwrite,
  output logic [1:0]       resultsrc,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic             w_rdy;
  logic             w_pcupdate;
  logic             w_branch;
  logic             w_retire;
  assign w_rdy     = mem_ready | ~MEM_WAIT;
  assign pcwrite   = w_pcupdate | (w_branch & zero);
  assign illegal   = r_state == S_TRAP;
  assign instret   = r_instret;
  assign state     = r_state;
  assign w_retire  = (w_next == S_FETCH) &&
                     (r_state == S_MEMWB || r_state == S_MEMWRITE ||
                      r_state == S_ALUWB || r_state == S_BEQ);
  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  // retired-instruction counter, bumped on each completing return to FETCH
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CNT_W'(1);
  // next state and Moore output decode; pcwrite adds the branch-taken term
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    w_pcupdate = 1'b0;
    w_branch   = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        irwrite    = w_rdy;
        w_pcupdate = w_rdy;
        w_next     = w_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        w_next  = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                  (opcode == OP_R)                     ? S_EXECR  :
                  (opcode == OP_I)                     ? S_EXECI  :
                  (opcode == OP_BEQ)                   ? S_BEQ    :
                  (opcode == OP_JAL && HAS_JAL)        ? S_JAL    : S_TRAP;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        w_next  = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
        w_next  = w_rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        w_next   = w_rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_JAL: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        w_pcupdate = 1'b1;
        w_next     = S_ALUWB;
      end
      S_BEQ: begin
        alusrca  = 2'b10;
        aluop    = 2'b01;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_TRAP;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven check of the multi-cycle controller plus trap, reset and wrap sequences
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mr0, ad0, mw0, ir0, pc0, rw0, il0, mr1, ad1, mw1, ir1, pc1, rw1, il1, mr2, ad2, mw2, ir2, pc2, rw2, il2;
  logic [1:0] rs0, a0, b0, op0, rs1, a1, b1, op1, rs2, a2, b2, op2;
  logic [31:0] cnt0, cnt2;
  logic [3:0] cnt1, st0, st1, st2;
  logic [14:0] o0, o1;
  int checks = 0;
  int errors = 0;
  localparam logic [6:0] R = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] AI = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b0000000;
  // {mem_req,adrsrc,memwrite,irwrite,pcwrite,regwrite}_resultsrc_alusrca_alusrcb_aluop_illegal
  localparam logic [14:0] F1 = 15'b100110_10_00_10_00_0;
  localparam logic [14:0] F0 = 15'b100000_10_00_10_00_0;
  localparam logic [14:0] DE = 15'b000000_00_01_01_00_0;
  localparam logic [14:0] MA = 15'b000000_00_10_01_00_0;
  localparam logic [14:0] MR = 15'b110000_00_00_00_00_0;
  localparam logic [14:0] MB = 15'b000001_01_00_00_00_0;
  localparam logic [14:0] MW = 15'b111000_00_00_00_00_0;
  localparam logic [14:0] ER = 15'b000000_00_10_00_10_0;
  localparam logic [14:0] EI = 15'b000000_00_10_01_10_0;
  localparam logic [14:0] AW = 15'b000001_00_00_00_00_0;
  localparam logic [14:0] JO = 15'b000010_00_01_10_00_0;
  localparam logic [14:0] B1 = 15'b000010_00_10_00_01_0;
  localparam logic [14:0] B0 = 15'b000000_00_10_00_01_0;
  localparam logic [14:0] TR = 15'b000000_00_00_00_00_1;
  typedef struct {
    logic        rn;
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [14:0] o;
    logic [31:0] cnt;
  } vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  multicycle_controller u0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mr0), .adrsrc(ad0), .memwrite(mw0), .irwrite(ir0), .pcwrite(pc0), .regwrite(rw0),
    .resultsrc(rs0), .alusrca(a0), .alusrcb(b0), .aluop(op0), .illegal(il0), .instret(cnt0), .state(st0)
  );
  multicycle_controller #(.CNT_W(4), .HAS_JAL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mr1), .adrsrc(ad1), .memwrite(mw1), .irwrite(ir1), .pcwrite(pc1), .regwrite(rw1),
    .resultsrc(rs1), .alusrca(a1), .alusrcb(b1), .aluop(op1), .illegal(il1), .instret(cnt1), .state(st1)
  );
  multicycle_controller #(.MEM_WAIT(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mr2), .adrsrc(ad2), .memwrite(mw2), .irwrite(ir2), .pcwrite(pc2), .regwrite(rw2),
    .resultsrc(rs2), .alusrca(a2), .alusrcb(b2), .aluop(op2), .illegal(il2), .instret(cnt2), .state(st2)
  );
  assign o0 = {mr0, ad0, mw0, ir0, pc0, rw0, rs0, a0, b0, op0, il0};
  assign o1 = {mr1, ad1, mw1, ir1, pc1, rw1, rs1, a1, b1, op1, il1};
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask
  task automatic add(input logic rn, input logic [6:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [14:0] o, input logic [31:0] cnt);
    vec_t e;
    e.rn = rn; e.op = op; e.z = z; e.rdy = rdy; e.st = st; e.o = o; e.cnt = cnt;
    v.push_back(e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    add(0, BAD, 0, 0, 0, F0, 0);
    add(1, R, 0, 1, 0, F1, 0);
    add(1, R, 0, 1, 1, DE, 0);
    add(1, R, 0, 1, 6, ER, 0);
    add(1, R, 0, 1, 7, AW, 0);
    add(1, LW, 0, 0, 0, F0, 1);
    add(1, LW, 0, 0, 0, F0, 1);
    add(1, LW, 0, 1, 0, F1, 1);
    add(1, LW, 0, 1, 1, DE, 1);
    add(1, LW, 0, 1, 2, MA, 1);
    add(1, LW, 0, 0, 3, MR, 1);
    add(1, LW, 0, 1, 3, MR, 1);
    add(1, LW, 0, 1, 4, MB, 1);
    add(1, SW, 0, 1, 0, F1, 2);
    add(1, SW, 0, 1, 1, DE, 2);
    add(1, SW, 0, 1, 2, MA, 2);
    add(1, SW, 0, 0, 5, MW, 2);
    add(1, SW, 0, 1, 5, MW, 2);
    add(1, BQ, 0, 1, 0, F1, 3);
    add(1, BQ, 1, 1, 1, DE, 3);
    add(1, BQ, 1, 1, 10, B1, 3);
    add(1, BQ, 1, 1, 0, F1, 4);
    add(1, BQ, 1, 1, 1, DE, 4);
    add(1, BQ, 0, 1, 10, B0, 4);
    add(1, AI, 0, 1, 0, F1, 5);
    add(1, AI, 0, 1, 1, DE, 5);
    add(1, AI, 0, 1, 8, EI, 5);
    add(1, AI, 0, 1, 7, AW, 5);
    add(1, JL, 0, 1, 0, F1, 6);
    add(1, JL, 0, 1, 1, DE, 6);
    add(1, JL, 0, 1, 9, JO, 6);
    add(1, JL, 0, 1, 7, AW, 6);
    add(1, BAD, 0, 1, 0, F1, 7);
    add(1, BAD, 0, 1, 1, DE, 7);
    add(1, BAD, 0, 1, 11, TR, 7);
    add(1, BAD, 1, 1, 11, TR, 7);
    foreach (v[i]) begin
      @(negedge clk);
      rst_n = v[i].rn; opcode = v[i].op; zero = v[i].z; mem_ready = v[i].rdy;
      #1;
      chk($sformatf("v%0d state", i), 32'(st0), 32'(v[i].st));
      chk($sformatf("v%0d outs", i), 32'(o0), 32'(v[i].o));
      chk($sformatf("v%0d instret", i), cnt0, v[i].cnt);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("nojal%0d state", k), 32'(st1), 32'd11);
      chk($sformatf("nojal%0d outs", k), 32'(o1), 32'(TR));
      chk($sformatf("nojal%0d instret", k), 32'(cnt1), 32'd6);
      chk($sformatf("trap%0d state", k), 32'(st0), 32'd11);
    end
    #2;
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    chk("async rst state", 32'(st0), 32'd0);
    chk("async rst illegal", 32'(il0), 32'd0);
    chk("async rst illegal u1", 32'(il1), 32'd0);
    chk("async rst outs", 32'(o0), 32'(F0));
    chk("async rst instret", cnt0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; opcode = AI; mem_ready = 1'b1;
    repeat (68) @(negedge clk);
    #1;
    chk("wrap state", 32'(st1), 32'd0);
    chk("wrap instret u1", 32'(cnt1), 32'd1);
    chk("addi instret u0", cnt0, 32'd17);
    opcode = SW;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("sw wait state", 32'(st0), 32'd5);
    chk("sw wait memwrite", 32'(mw0), 32'd1);
    chk("sw wait instret", cnt0, 32'd17);
    #1;
    rst_n = 1'b0;
    #1;
    chk("sw rst memwrite", 32'(mw0), 32'd0);
    chk("sw rst state", 32'(st0), 32'd0);
    chk("sw rst mem_req", 32'(mr0), 32'd1);
    chk("sw rst irwrite", 32'(ir0), 32'd0);
    chk("sw rst instret", cnt0, 32'd0);
    chk("nowait irwrite", 32'(ir2), 32'd1);
    chk("nowait pcwrite", 32'(pc2), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
